// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the memory-mapped SPI master.
//   - Register addresses as seen on the GPMC-side bus.
//   - Bit positions inside the setup and state registers.
//   - Shift-engine FSM state encoding and frame/divider widths.
`timescale 1ns/1ps

package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 8;
    localparam int unsigned BIT_CNT_WIDTH  = $clog2(SPI_FRAME_BITS);
    localparam int unsigned CLK_DIV_WIDTH  = 5;

    // Register map
    localparam int unsigned ADDR_SETUP = 0;
    localparam int unsigned ADDR_STATE = 2;
    localparam int unsigned ADDR_TX    = 4;
    localparam int unsigned ADDR_RX    = 6;

    // Setup register fields
    localparam int unsigned SETUP_SOFT_RST_BIT = 0;
    localparam int unsigned SETUP_DIV_LSB      = 1;
    localparam int unsigned SETUP_DIV_MSB      = 5;
    localparam int unsigned SETUP_START_BIT    = 6;

    // State register fields
    localparam int unsigned STATE_BUSY_BIT     = 0;
    localparam int unsigned STATE_NEW_DATA_BIT = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StRise,
        StFall,
        StDone
    } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 SPI frame engine (divider, FSM, shift registers).
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   soft_rst_i    level; forces the engine idle with sck/mosi low
//   start_i       one-cycle start request (ignored while busy)
//   clk_div_i     phase length minus one, latched at start
//   tx_byte_i     byte to send, latched at start
//   miso_i        serial input, sampled on the clk edge that raises sck
//   busy_o        frame in flight
//   done_o        high during the cycle whose closing edge completes the frame
//   rx_byte_o     shifted-in byte (valid when done_o is high)
//   sck_o, mosi_o, ss_n_o  SPI pins
// Build option: SPI_CS_EN drives ss_n low during the frame and appends one
// trailing phase (StDone) after the last sck falling edge.
`timescale 1ns/1ps

module spi_shift_engine
    import spi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      soft_rst_i,
    input  logic                      start_i,
    input  logic [CLK_DIV_WIDTH-1:0]  clk_div_i,
    input  logic [SPI_FRAME_BITS-1:0] tx_byte_i,
    input  logic                      miso_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [SPI_FRAME_BITS-1:0] rx_byte_o,
    output logic                      sck_o,
    output logic                      mosi_o,
    output logic                      ss_n_o
);

    spi_state_e                state_q;
    logic [CLK_DIV_WIDTH-1:0]  div_q;
    logic [CLK_DIV_WIDTH-1:0]  cnt_q;
    logic [BIT_CNT_WIDTH-1:0]  bit_q;
    logic [SPI_FRAME_BITS-1:0] tx_sh_q;
    logic [SPI_FRAME_BITS-1:0] rx_sh_q;
    logic                      sck_q;
    logic                      mosi_q;
    logic                      busy_q;
    logic                      phase_end;
    logic                      last_bit;
`ifdef SPI_CS_EN
    logic                      ss_n_q;
`endif

    assign phase_end = (cnt_q == div_q);
    assign last_bit  = (bit_q == BIT_CNT_WIDTH'(SPI_FRAME_BITS - 1));

    // Combinational so the register block captures rx and sets new_data on
    // the very edge where busy falls.
    always_comb begin
        done_o = 1'b0;
        if (!soft_rst_i && phase_end) begin
`ifdef SPI_CS_EN
            done_o = (state_q == StDone);
`else
            done_o = (state_q == StRise) && last_bit;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SPI_CS_EN
            ss_n_q  <= 1'b1;
`endif
        end else if (soft_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SPI_CS_EN
            ss_n_q  <= 1'b1;
`endif
        end else begin
            if (state_q != StIdle) begin
                cnt_q <= phase_end ? '0 : cnt_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StLead;
                        div_q   <= clk_div_i;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_sh_q <= tx_byte_i;
                        mosi_q  <= tx_byte_i[SPI_FRAME_BITS-1];
                        busy_q  <= 1'b1;
`ifdef SPI_CS_EN
                        ss_n_q  <= 1'b0;
`endif
                    end
                end
                StLead: begin
                    if (phase_end) begin
                        state_q <= StRise;
                        sck_q   <= 1'b1;
                        rx_sh_q <= {rx_sh_q[SPI_FRAME_BITS-2:0], miso_i};
                        bit_q   <= '0;
                    end
                end
                StRise: begin
                    if (phase_end) begin
                        sck_q <= 1'b0;
                        if (last_bit) begin
                            mosi_q  <= 1'b0;
`ifdef SPI_CS_EN
                            state_q <= StDone;
`else
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            state_q <= StFall;
                            tx_sh_q <= tx_sh_q << 1;
                            mosi_q  <= tx_sh_q[SPI_FRAME_BITS-2];
                        end
                    end
                end
                StFall: begin
                    if (phase_end) begin
                        state_q <= StRise;
                        sck_q   <= 1'b1;
                        rx_sh_q <= {rx_sh_q[SPI_FRAME_BITS-2:0], miso_i};
                        bit_q   <= bit_q + 1'b1;
                    end
                end
                StDone: begin
                    // Trailing slave-select hold phase.
                    if (phase_end) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
`ifdef SPI_CS_EN
                        ss_n_q  <= 1'b1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign rx_byte_o = rx_sh_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
`ifdef SPI_CS_EN
    assign ss_n_o    = ss_n_q;
`else
    assign ss_n_o    = 1'b1;
`endif

endmodule

// File: rtl/spi_master_regs.sv
// spi_master_regs: register front end of the SPI master behind the GPMC bus.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   cs, we, oe          active-low bus strobes
//   address, data_in    register address and write data
//   data_out            registered read data, held until the next read
//   sck, mosi, miso     SPI pins (mode 0, MSB first)
//   ss_n                slave select; tied high unless built with SPI_CS_EN
// Registers: 0 setup (soft_rst, clk_div, start), 2 state (busy, new_data),
// 4 tx holding byte, 6 rx last received byte (read clears new_data).
`timescale 1ns/1ps

module spi_master_regs
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  ss_n
);

    logic                      wr_stb;
    logic                      rd_stb;
    logic                      wr_setup;
    logic                      wr_tx;
    logic                      rd_rx;
    logic                      start;
    logic                      soft_rst_q;
    logic [CLK_DIV_WIDTH-1:0]  clk_div_q;
    logic [SPI_FRAME_BITS-1:0] tx_q;
    logic [SPI_FRAME_BITS-1:0] rx_q;
    logic                      new_data_q;
    logic [DATA_WIDTH-1:0]     data_out_q;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      busy;
    logic                      done;
    logic [SPI_FRAME_BITS-1:0] rx_byte;
    logic                      unused_data_in;

    assign unused_data_in = ^data_in[DATA_WIDTH-1:SPI_FRAME_BITS];

    assign wr_stb   = !cs && !we && oe;
    assign rd_stb   = !cs && we && !oe;
    assign wr_setup = wr_stb && (address == ADDR_WIDTH'(ADDR_SETUP));
    assign wr_tx    = wr_stb && (address == ADDR_WIDTH'(ADDR_TX));
    assign rd_rx    = rd_stb && (address == ADDR_WIDTH'(ADDR_RX));
    // A start written together with soft_rst=1 must not launch a frame.
    assign start    = wr_setup && data_in[SETUP_START_BIT] && !data_in[SETUP_SOFT_RST_BIT];

    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_WIDTH'(ADDR_SETUP): begin
                rd_data[SETUP_SOFT_RST_BIT]          = soft_rst_q;
                rd_data[SETUP_DIV_MSB:SETUP_DIV_LSB] = clk_div_q;
            end
            ADDR_WIDTH'(ADDR_STATE): begin
                rd_data[STATE_BUSY_BIT]     = busy;
                rd_data[STATE_NEW_DATA_BIT] = new_data_q;
            end
            ADDR_WIDTH'(ADDR_TX): rd_data[SPI_FRAME_BITS-1:0] = tx_q;
            ADDR_WIDTH'(ADDR_RX): rd_data[SPI_FRAME_BITS-1:0] = rx_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soft_rst_q <= 1'b0;
            clk_div_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            new_data_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (wr_setup) begin
                soft_rst_q <= data_in[SETUP_SOFT_RST_BIT];
                clk_div_q  <= data_in[SETUP_DIV_MSB:SETUP_DIV_LSB];
            end
            if (wr_tx) begin
                tx_q <= data_in[SPI_FRAME_BITS-1:0];
            end
            if (done) begin
                rx_q <= rx_byte;
            end
            // Completion beats a same-cycle rx read so no byte is lost.
            if (soft_rst_q) begin
                new_data_q <= 1'b0;
            end else if (done) begin
                new_data_q <= 1'b1;
            end else if (rd_rx) begin
                new_data_q <= 1'b0;
            end
            if (rd_stb) begin
                data_out_q <= rd_data;
            end
        end
    end

    assign data_out = data_out_q;

    spi_shift_engine u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst_i (soft_rst_q),
        .start_i    (start),
        .clk_div_i  (data_in[SETUP_DIV_MSB:SETUP_DIV_LSB]),
        .tx_byte_i  (tx_q),
        .miso_i     (miso),
        .busy_o     (busy),
        .done_o     (done),
        .rx_byte_o  (rx_byte),
        .sck_o      (sck),
        .mosi_o     (mosi),
        .ss_n_o     (ss_n)
    );

endmodule

// File: tb/tb_spi_master_regs.sv
`timescale 1ns/1ps

module tb_spi_master_regs;
    import spi_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
`ifdef SPI_CS_EN
    localparam int FrameMul = 17;
`else
    localparam int FrameMul = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          we;
    logic          oe;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          sck;
    logic          mosi;
    logic          miso;
    logic          ss_n;

    // 0 loopback, 1 tied high, 2 tied low, 3 inverted loopback
    int miso_mode;

    int checks = 0;
    int errors = 0;

    logic [7:0]    w_bits;
    int            w_rises;
    int            w_first;
    int            w_last;
    int            w_unstable;
    logic [DW-1:0] rd;

    always #5 clk = ~clk;

    always_comb begin
        case (miso_mode)
            0:       miso = mosi;
            1:       miso = 1'b1;
            2:       miso = 1'b0;
            default: miso = ~mosi;
        endcase
    end

    spi_master_regs #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .we       (we),
        .oe       (oe),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    typedef struct {
        string      name;
        logic [7:0] tx;
        int         div;
        int         mode;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[$];

    // Reference: what the slave side returns for a given tx byte.
    function automatic logic [7:0] model_rx(input logic [7:0] tx, input int mode);
        case (mode)
            0:       return tx;
            1:       return 8'hFF;
            2:       return 8'h00;
            default: return ~tx;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input int a, input int d);
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0; oe = 1'b1;
        address = AW'(a); data_in = DW'(d);
        @(posedge clk); #1;
        cs = 1'b1; we = 1'b1; oe = 1'b1;
    endtask

    task automatic bus_read(input int a, output logic [DW-1:0] d);
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b1; oe = 1'b0;
        address = AW'(a);
        @(posedge clk); #1;
        d = data_out;
        cs = 1'b1; oe = 1'b1;
    endtask

    // Called #1 after the start-write edge; sample k is taken #1 after the
    // k-th following edge. Records mosi at each observed sck rise.
    task automatic watch_frame(input int div, output logic [7:0] bits, output int rises,
                               output int first_rise, output int last_fall,
                               output int unstable);
        logic prev_sck;
        logic prev_mosi;
        int   budget;
        budget     = 20 * (div + 1) + 20;
        bits       = '0;
        rises      = 0;
        first_rise = -1;
        last_fall  = -1;
        unstable   = 0;
        prev_sck   = sck;
        prev_mosi  = mosi;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (sck && !prev_sck) begin
                if (rises == 0) first_rise = k;
                if (mosi !== prev_mosi) unstable++;
                if (rises < 8) bits[7-rises] = mosi;
                rises++;
            end
            if (!sck && prev_sck) begin
                last_fall = k;
                if (rises >= 8) break;
            end
            prev_sck  = sck;
            prev_mosi = mosi;
        end
    endtask

    task automatic run_vec(input string name, input logic [7:0] tx, input int div,
                           input int mode, input logic [7:0] exp_rx, input bit load_tx);
        logic [DW-1:0] r;
        miso_mode = mode;
        if (load_tx) bus_write(ADDR_TX, tx);
        bus_write(ADDR_SETUP, (div << 1) | (1 << 6));
        watch_frame(div, w_bits, w_rises, w_first, w_last, w_unstable);
        check({name, " rises"}, w_rises, 8);
        check({name, " mosi_bits"}, w_bits, tx);
        check({name, " first_rise"}, w_first, div + 1);
        check({name, " last_fall"}, w_last, 16 * (div + 1));
        check({name, " mosi_stable"}, w_unstable, 0);
`ifdef SPI_CS_EN
        repeat (div + 1) @(posedge clk);
`else
        check({name, " ss_n"}, ss_n, 1);
`endif
        bus_read(ADDR_STATE, r);
        check({name, " state_done"}, r, 2);
        bus_read(ADDR_RX, r);
        check({name, " rx"}, r, {8'h00, exp_rx});
        bus_read(ADDR_STATE, r);
        check({name, " state_clr"}, r, 0);
        bus_read(ADDR_SETUP, r);
        check({name, " setup"}, r, div << 1);
        bus_read(ADDR_TX, r);
        check({name, " tx"}, r, {8'h00, tx});
    endtask

    initial begin
        int sck_highs;

        cs = 1'b1; we = 1'b1; oe = 1'b1;
        address = '0; data_in = '0;
        miso_mode = 2;
        rst_n = 1'b0;
        #1;
        check("rst sck", sck, 0);
        check("rst mosi", mosi, 0);
        check("rst ss_n", ss_n, 1);
        check("rst data_out", data_out, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        bus_read(ADDR_SETUP, rd); check("rst setup", rd, 0);
        bus_read(ADDR_STATE, rd); check("rst state", rd, 0);
        bus_read(ADDR_TX, rd);    check("rst tx", rd, 0);
        bus_read(ADDR_RX, rd);    check("rst rx", rd, 0);

        // Unmapped addresses
        bus_write(8, 16'hFFFF);
        bus_write(1, 16'hFFFF);
        bus_read(8, rd);          check("unmapped rd8", rd, 0);
        bus_read(1, rd);          check("unmapped rd1", rd, 0);
        bus_read(ADDR_SETUP, rd); check("unmapped no_setup", rd, 0);
        bus_read(ADDR_TX, rd);    check("unmapped no_tx", rd, 0);
        bus_write(ADDR_TX, 16'hBE77);
        bus_read(ADDR_TX, rd);    check("tx upper_zero", rd, 16'h0077);

        // Table of frames: fixed corner vectors then random ones.
        vecs.push_back('{"loop_a5", 8'hA5, 0, 0, 8'hA5});
        vecs.push_back('{"tie1_3c", 8'h3C, 3, 1, 8'hFF});
        vecs.push_back('{"tie0_f0", 8'hF0, 1, 2, 8'h00});
        vecs.push_back('{"inv_81",  8'h81, 2, 3, 8'h7E});
        for (int i = 0; i < 6; i++) begin
            logic [7:0] t;
            int         dv;
            int         md;
            t  = 8'($urandom);
            dv = $urandom_range(0, 4);
            md = $urandom_range(0, 3);
            vecs.push_back('{$sformatf("rand%0d", i), t, dv, md, model_rx(t, md)});
        end
        foreach (vecs[i]) begin
            run_vec(vecs[i].name, vecs[i].tx, vecs[i].div, vecs[i].mode, vecs[i].exp_rx, 1'b1);
        end

        // Start while busy and tx rewrite mid-frame.
        miso_mode = 0;
        bus_write(ADDR_TX, 8'h5A);
        bus_write(ADDR_SETUP, (2 << 1) | (1 << 6));
        fork
            watch_frame(2, w_bits, w_rises, w_first, w_last, w_unstable);
            begin
                repeat (6) @(posedge clk);
                bus_write(ADDR_SETUP, 1 << 6);
                bus_write(ADDR_TX, 8'h11);
            end
        join
        check("busy_wr mosi_bits", w_bits, 8'h5A);
        check("busy_wr last_fall", w_last, 48);
        repeat (4) @(posedge clk);
        bus_read(ADDR_RX, rd);    check("busy_wr rx", rd, 16'h005A);
        bus_read(ADDR_TX, rd);    check("busy_wr tx_hold", rd, 16'h0011);
        bus_read(ADDR_SETUP, rd); check("busy_wr setup", rd, 0);
        run_vec("next_11", 8'h11, 1, 0, 8'h11, 1'b0);

        // Rx read landing in the completion cycle of a second frame.
        miso_mode = 0;
        bus_write(ADDR_TX, 8'hC3);
        bus_write(ADDR_SETUP, 1 << 6);
        repeat (FrameMul + 2) @(posedge clk);
        bus_read(ADDR_STATE, rd); check("dc nd_pending", rd, 2);
        bus_write(ADDR_TX, 8'h3C);
        bus_write(ADDR_SETUP, 1 << 6);
        repeat (FrameMul - 1) @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b1; oe = 1'b0; address = AW'(ADDR_RX);
        @(posedge clk); #1;
        rd = data_out;
        cs = 1'b1; oe = 1'b1;
        check("dc rx_old", rd, 16'h00C3);
        bus_read(ADDR_STATE, rd); check("dc nd_kept", rd, 2);
        bus_read(ADDR_RX, rd);    check("dc rx_new", rd, 16'h003C);
        bus_read(ADDR_STATE, rd); check("dc nd_clr", rd, 0);

        // Soft reset mid-frame; leave new_data set beforehand.
        miso_mode = 1;
        bus_write(ADDR_SETUP, 1 << 6);
        repeat (FrameMul + 2) @(posedge clk);
        bus_write(ADDR_TX, 8'hFF);
        bus_write(ADDR_SETUP, (3 << 1) | (1 << 6));
        repeat (8) @(posedge clk);
        bus_read(ADDR_STATE, rd); check("srst busy_nd", rd, 3);
        bus_write(ADDR_SETUP, (3 << 1) | 1);
        @(posedge clk); #1;
        check("srst sck", sck, 0);
        check("srst mosi", mosi, 0);
        bus_write(ADDR_SETUP, (3 << 1) | 1 | (1 << 6));
        sck_highs = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (sck) sck_highs++;
        end
        check("srst no_sck", sck_highs, 0);
        bus_read(ADDR_STATE, rd); check("srst state", rd, 0);
        bus_read(ADDR_SETUP, rd); check("srst setup", rd, 7);
        bus_read(ADDR_TX, rd);    check("srst tx_kept", rd, 16'h00FF);
        bus_write(ADDR_SETUP, 3 << 1);
        run_vec("after_srst", 8'hFF, 3, 1, 8'hFF, 1'b0);

        // Asynchronous reset in the middle of a frame.
        bus_write(ADDR_TX, 8'h96);
        bus_read(ADDR_TX, rd);    check("arst pre_dout", rd, 16'h0096);
        bus_write(ADDR_SETUP, (3 << 1) | (1 << 6));
        repeat (5) @(posedge clk);
        #2;
        check("arst pre_sck", sck, 1);
        rst_n = 1'b0;
        #1;
        check("arst sck", sck, 0);
        check("arst ss_n", ss_n, 1);
        check("arst mosi", mosi, 0);
        check("arst data_out", data_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_read(ADDR_STATE, rd); check("arst state", rd, 0);
        bus_read(ADDR_RX, rd);    check("arst rx", rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
